hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage CPU. Drives the IF/ID register's hold and flush inputs, the PC write enable, the ID/EX bubble and the back-end freeze.
- Resolves three event classes:
  - load-use data hazards;
  - taken branches resolved in ID;
  - multi-cycle data-memory waits.
- Includes a sticky watchdog that halts the pipeline if memory never responds.

Parameters:
- TIMEOUT, 255, max consecutive stalled memory cycles before ERROR; legal range 2..2^CNT_W-1.
- CNT_W, 8, width of the wait counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- ifid_rs_i  in  5  rs field of the instruction in IF/ID.
- ifid_rt_i  in  5  rt field of the instruction in IF/ID.
- ifid_uses_rt_i  in  1  instruction in IF/ID reads rt as a source.
- idex_memread_i  in  1  instruction in ID/EX is a load.
- idex_rt_i  in  5  destination register of the ID/EX load.
- branch_taken_i  in  1  branch in ID resolved taken this cycle.
- mem_req_i  in  1  MEM stage issuing a data-memory access.
- mem_ready_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  1 = PC updates.
- ifid_hold_o  out  1  1 = IF/ID holds its contents (stall); 0 = IF/ID loads.
- ifid_flush_o  out  1  1 = IF/ID loads a zero instruction.
- idex_bubble_o  out  1  1 = zero the control fields written into ID/EX.
- pipe_freeze_o  out  1  1 = ID/EX, EX/MEM and MEM/WB hold.
- error_o  out  1  watchdog fired; sticky until reset.
- stall_cycles_o  out  32  performance counter (optional feature).
- flush_count_o  out  32  performance counter (optional feature).

Behaviour:
- State machine states: RUN, MEM_WAIT, ERROR. Reset → RUN, wait_cnt=0.
- Outputs are combinational from state and inputs, so stalls act in the same cycle.
- While rst_i is high, outputs are forced to: pc_write_o=0, ifid_hold_o=1, ifid_flush_o=0, idex_bubble_o=1, pipe_freeze_o=1, error_o=0, counters=0.
- lu (load-use) = idex_memread_i && idex_rt_i!=0 && (idex_rt_i==ifid_rs_i || (ifid_uses_rt_i && idex_rt_i==ifid_rt_i)).
- ms (memory stall) = mem_req_i && !mem_ready_i.
- RUN, priority ms > lu > branch:
  - ms: freeze everything: pc_write_o=0, ifid_hold_o=1, pipe_freeze_o=1, idex_bubble_o=0, ifid_flush_o=0. wait_cnt←1; next state MEM_WAIT.
  - lu: pc_write_o=0, ifid_hold_o=1, idex_bubble_o=1, ifid_flush_o=0. branch_taken_i is ignored (operands stale); the branch re-resolves next cycle.
  - branch_taken_i: pc_write_o=1, ifid_hold_o=0, ifid_flush_o=1.
  - Otherwise: pc_write_o=1; all other outputs 0.
- MEM_WAIT:
  - mem_ready_i=0: same outputs as RUN/ms.
    - wait_cnt==TIMEOUT: next state ERROR.
    - Otherwise: wait_cnt←wait_cnt+1.
  - mem_ready_i=1: outputs computed exactly as in RUN (lu and branch evaluated; ms is 0). Next state RUN; wait_cnt←0.
- ERROR: all outputs in frozen form (pc_write_o=0, ifid_hold_o=1, pipe_freeze_o=1), error_o=1. Left only by reset.
- ifid_flush_o and ifid_hold_o are never both 1. pc_write_o==!ifid_hold_o in every state.
- Reset asserted mid-MEM_WAIT returns to RUN with wait_cnt=0 and no residual stall.

Optional Feature:
- HAZARD_PERF_EN defined:
  - stall_cycles_o increments on every cycle with pc_write_o=0 and state!=ERROR.
  - flush_count_o increments on every cycle with ifid_flush_o=1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on reset.
- HAZARD_PERF_EN undefined: both ports tied to 0 and no counter flops are instantiated.

Test Plan:
- Load-use: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 for one cycle → pc_write_o=0, ifid_hold_o=1, idex_bubble_o=1 that cycle. Next cycle with idex_memread_i=0 → normal flow.
- Load to $0: idex_rt_i=0, ifid_rs_i=0 → no stall, pc_write_o=1. With ifid_uses_rt_i=0 and rt matching only → no stall.
- Branch: branch_taken_i=1, no hazard → ifid_flush_o=1, pc_write_o=1. Branch plus lu in the same cycle → stall only, flush=0; flush=1 on the following cycle.
- Memory wait: mem_req_i=1, mem_ready_i=0 for 3 cycles, then ready → pipe_freeze_o=1 for exactly 3 cycles, released on the ready cycle. If branch_taken_i=1 on the ready cycle → flush fires on that cycle.
- Watchdog, TIMEOUT=4, ready held 0 → frozen 5 cycles then ERROR: error_o=1 and stays 1 after req drops. Asserting rst_i → RUN, error_o=0.
- HAZARD_PERF_EN: 2 lu stalls + 3 memory-wait cycles + 1 flush → stall_cycles_o=5, flush_count_o=1. Without the macro both read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, ID-branch flushes, memory-wait freeze, sticky watchdog.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  input  logic        ifid_uses_rt_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  input  logic        branch_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        ifid_hold_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        pipe_freeze_o,
  output logic        error_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             lu, ms, frozen, err;

  assign lu = idex_memread_i && (idex_rt_i != 5'd0) &&
              ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));
  assign ms = mem_req_i && !mem_ready_i;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    frozen        = 1'b0;
    err           = 1'b0;
    pc_write_o    = 1'b1;
    ifid_hold_o   = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;
    error_o       = 1'b0;

    case (state_q)
      RUN: begin
        if (ms) begin
          frozen     = 1'b1;
          wait_cnt_d = CNT_W'(1);
          state_d    = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready_i) begin
          frozen = 1'b1;
          if (wait_cnt_q == TIMEOUT_C) state_d = ERROR;
          else                         wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      ERROR: begin
        frozen = 1'b1;
        err    = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    // A stale branch under a load-use stall is dropped; it re-resolves once operands arrive.
    if (frozen) begin
      pc_write_o    = 1'b0;
      ifid_hold_o   = 1'b1;
      pipe_freeze_o = 1'b1;
      error_o       = err;
    end else if (lu) begin
      pc_write_o    = 1'b0;
      ifid_hold_o   = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
    end

    if (rst_i) begin
      pc_write_o    = 1'b0;
      ifid_hold_o   = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b1;
      pipe_freeze_o = 1'b1;
      error_o       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // ERROR cycles are excluded so a dead memory does not swamp the stall count.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_write_o && (state_q != ERROR)) stall_cycles_d = stall_cycles_q + 32'd1;
    if (ifid_flush_o)                      flush_count_d  = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  assign stall_cycles_o = 32'd0;
  assign flush_count_o  = 32'd0;
`endif

endmodule
